// File: rtl/ex_alu_unit.sv
// Execute-stage ALU: single-cycle logic/arithmetic ops with 1-cycle latency, plus a
// multi-cycle shift-add multiplier that holds off new ops while it iterates.
module ex_alu_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             out_valid,
    output logic             illegal_op
);

    localparam logic [0:0] StIdle   = 1'b0;
    localparam logic [0:0] StMulRun = 1'b1;

    localparam logic [3:0] OpAnd = 4'b0000;
    localparam logic [3:0] OpOr  = 4'b0001;
    localparam logic [3:0] OpAdd = 4'b0010;
    localparam logic [3:0] OpSub = 4'b0110;
    localparam logic [3:0] OpSlt = 4'b0111;
    localparam logic [3:0] OpNor = 4'b1100;
    localparam logic [3:0] OpMul = 4'b1000;

    logic [0:0]       state_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] alu_res;
    logic             alu_illegal;
    logic [WIDTH-1:0] mul_sum;
    logic             mul_last;
    logic             slt_bit;

    assign in_ready = (state_q == StIdle) & ~reset;

    always_comb begin
        alu_res     = '0;
        alu_illegal = 1'b0;
        slt_bit     = $signed(operand_a) < $signed(operand_b);
        case (alu_control)
            OpAnd:   alu_res = operand_a & operand_b;
            OpOr:    alu_res = operand_a | operand_b;
            OpAdd:   alu_res = operand_a + operand_b;
            OpSub:   alu_res = operand_a - operand_b;
            OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
            OpNor:   alu_res = ~(operand_a | operand_b);
            default: alu_illegal = 1'b1;
        endcase
    end

    // Accumulator value including this iteration's partial product; used for the final write.
    assign mul_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_last = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            result     <= '0;
            zero       <= 1'b1;
            out_valid  <= 1'b0;
            illegal_op <= 1'b0;
            cnt_q      <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
        end else begin
            out_valid  <= 1'b0;
            illegal_op <= 1'b0;
            if (flush) begin
                state_q <= StIdle;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (in_valid) begin
                            if (alu_control == OpMul) begin
                                mcand_q  <= operand_a;
                                mplier_q <= operand_b;
                                acc_q    <= '0;
                                cnt_q    <= '0;
                                state_q  <= StMulRun;
                            end else begin
                                result     <= alu_res;
                                zero       <= (alu_res == '0);
                                out_valid  <= 1'b1;
                                illegal_op <= alu_illegal;
                            end
                        end
                    end
                    StMulRun: begin
                        acc_q    <= mul_sum;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + CNT_W'(1);
                        if (mul_last) begin
                            result    <= mul_sum;
                            zero      <= (mul_sum == '0);
                            out_valid <= 1'b1;
                            state_q   <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ex_alu_unit.sv
// Self-checking bench for ex_alu_unit: directed vector table, multi-cycle MUL/flush/reset
// sequences, and randomized ops against an arithmetic reference model.
module tb_ex_alu_unit;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_control;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] result;
    logic        zero;
    logic        out_valid;
    logic        illegal_op;

    int vectors = 0;
    int errors  = 0;

    ex_alu_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_control(alu_control),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .result     (result),
        .zero       (zero),
        .out_valid  (out_valid),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zr;
        logic        ill;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: results straight from the operation definitions.
    function automatic void ref_model(input logic [3:0] op, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] r,
                                      output logic ill, output logic is_mul);
        r      = 32'd0;
        ill    = 1'b0;
        is_mul = 1'b0;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: r = ~(a | b);
            4'b1000: begin r = a * b; is_mul = 1'b1; end
            default: ill = 1'b1;
        endcase
    endfunction

    task automatic run_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic hold_valid);
        int lat;
        logic [31:0] er;
        logic ei, em;
        ref_model(4'b1000, a, b, er, ei, em);
        alu_control = 4'b1000;
        operand_a   = a;
        operand_b   = b;
        in_valid    = 1'b1;
        tick();
        if (hold_valid) begin
            alu_control = 4'b0010;
        end else begin
            in_valid = 1'b0;
        end
        lat = -1;
        for (int j = 0; j <= 40; j++) begin
            if (out_valid) begin
                lat = j;
                break;
            end
            if (in_ready) begin
                lat = -2;
                break;
            end
            tick();
        end
        in_valid = 1'b0;
        chk({name, " latency"}, lat, 32);
        chk({name, " result"}, result, er);
        chk({name, " zero"}, zero, (er == 32'd0));
        chk({name, " illegal"}, illegal_op, 1'b0);
        chk({name, " in_ready after"}, in_ready, 1'b1);
    endtask

    initial begin
        logic [31:0] er, a, b, held;
        logic        ei, em;
        logic [3:0]  op;
        int          bad;
        logic [3:0]  legal[7];

        tbl[0] = '{"add_ovf",  4'b0010, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1'b0};
        tbl[1] = '{"sub_eq",   4'b0110, 32'd5,         32'd5,         32'd0,         1'b1, 1'b0};
        tbl[2] = '{"slt_neg",  4'b0111, 32'hFFFF_FFFF, 32'h1,         32'd1,         1'b0, 1'b0};
        tbl[3] = '{"nor_zero", 4'b1100, 32'd0,         32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0};
        tbl[4] = '{"and",      4'b0000, 32'hF0F0,      32'h0FF0,      32'h00F0,      1'b0, 1'b0};
        tbl[5] = '{"illegal",  4'b1111, 32'h1234,      32'h5678,      32'd0,         1'b1, 1'b1};
        tbl[6] = '{"or",       4'b0001, 32'hA000_0005, 32'h0500_0050, 32'hA500_0055, 1'b0, 1'b0};
        tbl[7] = '{"slt_pos",  4'b0111, 32'h1,         32'hFFFF_FFFF, 32'd0,         1'b1, 1'b0};
        tbl[8] = '{"add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h1,         32'd0,         1'b1, 1'b0};
        tbl[9] = '{"sub_wrap", 4'b0110, 32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0, 1'b0};

        legal[0] = 4'b0000; legal[1] = 4'b0001; legal[2] = 4'b0010; legal[3] = 4'b0110;
        legal[4] = 4'b0111; legal[5] = 4'b1100; legal[6] = 4'b1000;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
        alu_control = 4'b0; operand_a = 32'd0; operand_b = 32'd0;
        tick();
        tick();
        chk("rst in_ready low", in_ready, 1'b0);
        chk("rst result", result, 32'd0);
        chk("rst zero", zero, 1'b1);
        chk("rst out_valid", out_valid, 1'b0);
        chk("rst illegal", illegal_op, 1'b0);
        reset = 1'b0;
        #1;
        chk("rst in_ready high", in_ready, 1'b1);

        // Back-to-back table vectors: one accepted and completed every cycle.
        for (int i = 0; i < 10; i++) begin
            alu_control = tbl[i].op;
            operand_a   = tbl[i].a;
            operand_b   = tbl[i].b;
            in_valid    = 1'b1;
            tick();
            chk({tbl[i].name, " out_valid"}, out_valid, 1'b1);
            chk({tbl[i].name, " result"}, result, tbl[i].res);
            chk({tbl[i].name, " zero"}, zero, tbl[i].zr);
            chk({tbl[i].name, " illegal"}, illegal_op, tbl[i].ill);
        end
        in_valid = 1'b0;
        tick();
        chk("idle out_valid", out_valid, 1'b0);
        chk("idle result hold", result, 32'hFFFF_FFFF);

        // MUL with in_valid held during the run; the held op must not be accepted.
        run_mul("mul_12345", 32'h0001_2345, 32'h0000_0100, 1'b1);
        chk("mul_12345 exact", result, 32'h0123_4500);
        tick();
        chk("mul no extra out_valid", out_valid, 1'b0);

        // Flush mid-MUL: no completion, result unchanged.
        held = result;
        alu_control = 4'b1000; operand_a = 32'd3; operand_b = 32'd7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int j = 0; j < 9; j++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush out_valid", out_valid, 1'b0);
        chk("flush in_ready", in_ready, 1'b1);
        chk("flush result hold", result, held);
        bad = 0;
        for (int j = 0; j < 40; j++) begin
            tick();
            if (out_valid) bad++;
        end
        chk("flush no late out_valid", bad, 0);

        // Flush with an in_valid in the same cycle drops the op.
        alu_control = 4'b0010; operand_a = 32'd1; operand_b = 32'd1; in_valid = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush drops op", out_valid, 1'b0);
        chk("flush drops result", result, held);

        // Reset mid-MUL.
        alu_control = 4'b0010; operand_a = 32'd1; operand_b = 32'd2; in_valid = 1'b1;
        tick();
        chk("pre-reset add", result, 32'd3);
        alu_control = 4'b1000; operand_a = 32'd3; operand_b = 32'd7;
        tick();
        in_valid = 1'b0;
        for (int j = 0; j < 5; j++) tick();
        reset = 1'b1;
        tick();
        chk("midmul rst result", result, 32'd0);
        chk("midmul rst zero", zero, 1'b1);
        chk("midmul rst out_valid", out_valid, 1'b0);
        chk("midmul rst in_ready low", in_ready, 1'b0);
        reset = 1'b0;
        #1;
        chk("midmul rst in_ready high", in_ready, 1'b1);
        bad = 0;
        for (int j = 0; j < 40; j++) begin
            tick();
            if (out_valid) bad++;
        end
        chk("midmul rst no completion", bad, 0);

        // Randomized ops against the reference model.
        for (int n = 0; n < 400; n++) begin
            int idx;
            idx = $urandom_range(0, 7);
            op  = (idx == 7) ? 4'($urandom) : legal[idx];
            a   = $urandom;
            b   = $urandom;
            if ($urandom_range(0, 3) == 0) b = a;
            if ($urandom_range(0, 5) == 0) a = a >> $urandom_range(0, 31);
            ref_model(op, a, b, er, ei, em);
            if (em) begin
                run_mul("rnd mul", a, b, 1'b0);
            end else begin
                alu_control = op; operand_a = a; operand_b = b; in_valid = 1'b1;
                tick();
                in_valid = 1'b0;
                chk("rnd out_valid", out_valid, 1'b1);
                chk("rnd result", result, er);
                chk("rnd zero", zero, (er == 32'd0));
                chk("rnd illegal", illegal_op, ei);
            end
            if ($urandom_range(0, 3) == 0) begin
                tick();
                chk("rnd gap out_valid", out_valid, 1'b0);
                chk("rnd gap hold", result, er);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
